// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared state encoding and widths for the memory-game controller
// Build option: REVEAL_TIMER_EN adds the REVEAL state.
package game_pkg;

    localparam int PLAYER_W = 2;
    localparam int TILE_W   = 4;

    typedef enum logic [3:0] {
        IDLE    = 4'd0,
        SELECT  = 4'd1,
        COMPARE = 4'd2,
        WAIT_GO = 4'd3,
        MOVE    = 4'd4,
        CHECK   = 4'd5,
`ifdef REVEAL_TIMER_EN
        REVEAL  = 4'd6,
`endif
        NEXT    = 4'd7,
        WIN     = 4'd8
    } state_t;

    // Advance the turn, wrapping back to player 0 once the count is reached.
    function automatic logic [PLAYER_W-1:0] next_player(
        input logic [PLAYER_W-1:0] cur,
        input logic [PLAYER_W:0]   players
    );
        logic [PLAYER_W:0] inc;
        inc = {1'b0, cur} + 3'd1;
        return (inc >= players) ? '0 : inc[PLAYER_W-1:0];
    endfunction

endpackage

// File: rtl/edge_pulse.sv
// rtl/edge_pulse.sv - registered rising-edge detector for a button level
// Ports: clk, rst (sync, active-high), din (button level), pulse (one cycle per rising edge).
module edge_pulse (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic pulse
);

    logic sync_q, sync_d;
    logic prev_q, prev_d;
    logic armed_q, armed_d;

    // On the first cycle after reset the history register is loaded with the
    // live level, so a button already held at reset release never fires.
    always_comb begin
        sync_d  = din;
        prev_d  = armed_q ? sync_q : din;
        armed_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q  <= 1'b0;
            prev_q  <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            prev_q  <= prev_d;
            armed_q <= armed_d;
        end
    end

    assign pulse = sync_q & ~prev_q;

endmodule

// File: rtl/game_control.sv
// rtl/game_control.sv - turn/compare/win sequencing FSM for the memory game
// Ports: clk, rst (sync, active-high); start, flip (button levels); N (player-count code);
//        go (match result, cycle after A); W (win flag, cycle after B);
//        A (compare strobe), B (advance strobe), statecombo_next_turn (turn pass);
//        player, game_over, winner.
// Build option: REVEAL_TIMER_EN keeps a mismatched tile revealed for REVEAL_CYCLES cycles.
module game_control
    import game_pkg::*;
#(
    parameter int REVEAL_CYCLES = 25_000_000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                flip,
    input  logic [1:0]          N,
    input  logic                go,
    input  logic                W,
    output logic                A,
    output logic                B,
    output logic                statecombo_next_turn,
    output logic [PLAYER_W-1:0] player,
    output logic                game_over,
    output logic [PLAYER_W-1:0] winner
);

    logic start_ev;
    logic flip_ev;

    edge_pulse u_start_edge (
        .clk   (clk),
        .rst   (rst),
        .din   (start),
        .pulse (start_ev)
    );

    edge_pulse u_flip_edge (
        .clk   (clk),
        .rst   (rst),
        .din   (flip),
        .pulse (flip_ev)
    );

    state_t                state_q, state_d;
    logic [PLAYER_W-1:0]   player_q, player_d;
    logic [PLAYER_W-1:0]   winner_q, winner_d;
    logic [PLAYER_W:0]     players_q, players_d;

`ifdef REVEAL_TIMER_EN
    localparam int CNT_W = (REVEAL_CYCLES > 1) ? $clog2(REVEAL_CYCLES) : 1;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
`else
    logic                  unused_reveal_cfg;
    assign unused_reveal_cfg = ^REVEAL_CYCLES;
`endif

    always_comb begin
        state_d   = state_q;
        player_d  = player_q;
        winner_d  = winner_q;
        players_d = players_q;
`ifdef REVEAL_TIMER_EN
        cnt_d     = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                // Start wins over a coincident flip; flip has no meaning here.
                if (start_ev) begin
                    players_d = (N == 2'd0) ? 3'd2 : ({1'b0, N} + 3'd1);
                    player_d  = '0;
                    state_d   = SELECT;
                end
            end
            SELECT: begin
                if (flip_ev) begin
                    state_d = COMPARE;
                end
            end
            COMPARE: state_d = WAIT_GO;
            WAIT_GO: begin
                if (go) begin
                    state_d = MOVE;
                end else begin
`ifdef REVEAL_TIMER_EN
                    // Counter holds the cycles left after the current one.
                    cnt_d   = CNT_W'(REVEAL_CYCLES - 1);
                    state_d = REVEAL;
`else
                    state_d = NEXT;
`endif
                end
            end
            MOVE: state_d = CHECK;
            CHECK: begin
                if (W) begin
                    winner_d = player_q;
                    state_d  = WIN;
                end else begin
                    state_d = SELECT;
                end
            end
`ifdef REVEAL_TIMER_EN
            REVEAL: begin
                if (cnt_q == '0) begin
                    state_d = NEXT;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
`endif
            NEXT: begin
                player_d = next_player(player_q, players_q);
                state_d  = SELECT;
            end
            WIN: begin
                if (start_ev) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            player_q  <= '0;
            winner_q  <= '0;
            players_q <= 3'd2;
`ifdef REVEAL_TIMER_EN
            cnt_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            player_q  <= player_d;
            winner_q  <= winner_d;
            players_q <= players_d;
`ifdef REVEAL_TIMER_EN
            cnt_q     <= cnt_d;
`endif
        end
    end

    // Strobes decode directly from state, so at most one can ever be high.
    assign A                    = (state_q == COMPARE);
    assign B                    = (state_q == MOVE);
    assign statecombo_next_turn = (state_q == NEXT);
    assign game_over            = (state_q == WIN);
    assign player               = player_q;
    assign winner               = winner_q;

endmodule

// File: tb/tb_game_control.sv
// tb/tb_game_control.sv - directed self-checking bench for game_control
module tb_game_control;

    logic       clk;
    logic       rst;
    logic       start;
    logic       flip;
    logic [1:0] N;
    logic       go;
    logic       W;
    logic       A;
    logic       B;
    logic       nt;
    logic [1:0] player;
    logic       game_over;
    logic [1:0] winner;

    int checks;
    int errors;
    int a_cnt;
    int nt_cnt;

`ifdef REVEAL_TIMER_EN
    localparam int NT_LAT = 5;
`else
    localparam int NT_LAT = 1;
`endif

    game_control #(.REVEAL_CYCLES(4)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .start                (start),
        .flip                 (flip),
        .N                    (N),
        .go                   (go),
        .W                    (W),
        .A                    (A),
        .B                    (B),
        .statecombo_next_turn (nt),
        .player               (player),
        .game_over            (game_over),
        .winner               (winner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
        checks++;
        if ($countones({A, B, nt}) > 1) begin
            errors++;
            $display("FAIL exclusive: A=%0b B=%0b next_turn=%0b, at most one may be high", A, B, nt);
        end
        if (A) a_cnt++;
        if (nt) nt_cnt++;
    endtask

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; flip = 1'b0; go = 1'b0; W = 1'b0;
        tick(); tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic press_start();
        start = 1'b1; tick(); tick();
        start = 1'b0; tick();
    endtask

    // Leaves the FSM in COMPARE when called from SELECT.
    task automatic press_flip();
        flip = 1'b1; tick(); tick();
        flip = 1'b0;
    endtask

    // Called while in WAIT_GO; k = ticks until statecombo_next_turn, 0 if never.
    task automatic wait_next_turn(output int k);
        k = 0;
        for (int i = 1; i <= 30; i++) begin
            tick();
            if (nt) begin
                k = i;
                break;
            end
        end
    endtask

    task automatic mismatch_turn();
        int k;
        press_flip();
        go = 1'b0;
        tick();
        wait_next_turn(k);
        tick();
    endtask

    task automatic test_reset();
        int a0;
        do_reset();
        checks++; if (A !== 1'b0) begin errors++; $display("FAIL reset_A: got %0b expected 0", A); end
        checks++; if (B !== 1'b0) begin errors++; $display("FAIL reset_B: got %0b expected 0", B); end
        checks++; if (nt !== 1'b0) begin errors++; $display("FAIL reset_next_turn: got %0b expected 0", nt); end
        checks++; if (player !== 2'd0) begin errors++; $display("FAIL reset_player: got %0d expected 0", player); end
        checks++; if (winner !== 2'd0) begin errors++; $display("FAIL reset_winner: got %0d expected 0", winner); end
        checks++; if (game_over !== 1'b0) begin errors++; $display("FAIL reset_game_over: got %0b expected 0", game_over); end
        // Buttons held across reset release must not produce events.
        N = 2'd2;
        rst = 1'b1; start = 1'b1; flip = 1'b1;
        tick(); tick();
        rst = 1'b0;
        repeat (4) tick();
        start = 1'b0; flip = 1'b0;
        tick(); tick();
        a0 = a_cnt;
        press_flip(); tick();
        checks++; if (a_cnt !== a0) begin errors++; $display("FAIL held_start_at_reset: A pulses got %0d expected 0", a_cnt - a0); end
        press_start();
        press_flip();
        checks++; if (A !== 1'b1) begin errors++; $display("FAIL start_after_release: A got %0b expected 1", A); end
    endtask

    task automatic test_match_no_win();
        N = 2'd2;
        do_reset();
        press_start();
        press_flip();
        checks++; if (A !== 1'b1) begin errors++; $display("FAIL match_A: got %0b expected 1", A); end
        go = 1'b1; tick();
        checks++; if (A !== 1'b0 || B !== 1'b0) begin errors++; $display("FAIL match_wait_go: A=%0b B=%0b expected 0 0", A, B); end
        tick(); go = 1'b0;
        checks++; if (B !== 1'b1) begin errors++; $display("FAIL match_B: got %0b expected 1", B); end
        W = 1'b0; tick();
        checks++; if (B !== 1'b0) begin errors++; $display("FAIL match_B_width: got %0b expected 0", B); end
        tick();
        checks++; if (player !== 2'd0) begin errors++; $display("FAIL match_player: got %0d expected 0", player); end
        checks++; if (game_over !== 1'b0) begin errors++; $display("FAIL match_game_over: got %0b expected 0", game_over); end
        press_flip();
        checks++; if (A !== 1'b1) begin errors++; $display("FAIL match_back_in_select: A got %0b expected 1", A); end
    endtask

    task automatic test_mismatch_reveal();
        int k;
        N = 2'd1;
        do_reset();
        press_start();
        press_flip();
        go = 1'b0; tick();
        checks++; if (nt !== 1'b0) begin errors++; $display("FAIL mismatch_nt_in_wait_go: got %0b expected 0", nt); end
        wait_next_turn(k);
        checks++; if (k !== NT_LAT) begin errors++; $display("FAIL mismatch_latency: got %0d expected %0d", k, NT_LAT); end
        checks++; if (player !== 2'd0) begin errors++; $display("FAIL mismatch_player_during_next: got %0d expected 0", player); end
        tick();
        checks++; if (player !== 2'd1) begin errors++; $display("FAIL mismatch_player_advance: got %0d expected 1", player); end
        checks++; if (nt !== 1'b0) begin errors++; $display("FAIL mismatch_nt_width: got %0b expected 0", nt); end
        press_flip();
        go = 1'b0; tick();
        wait_next_turn(k);
        checks++; if (k !== NT_LAT) begin errors++; $display("FAIL mismatch_latency2: got %0d expected %0d", k, NT_LAT); end
        tick();
        checks++; if (player !== 2'd0) begin errors++; $display("FAIL mismatch_wrap: got %0d expected 0", player); end
    endtask

    task automatic test_player_counts();
        int exp_n3[4];
        exp_n3 = '{1, 2, 3, 0};
        N = 2'd0;
        do_reset();
        press_start();
        mismatch_turn();
        checks++; if (player !== 2'd1) begin errors++; $display("FAIL n0_first: got %0d expected 1", player); end
        mismatch_turn();
        checks++; if (player !== 2'd0) begin errors++; $display("FAIL n0_clamp_wrap: got %0d expected 0", player); end
        N = 2'd3;
        do_reset();
        press_start();
        for (int i = 0; i < 4; i++) begin
            mismatch_turn();
            checks++;
            if (player !== 2'(exp_n3[i])) begin
                errors++;
                $display("FAIL n3_turn%0d: got %0d expected %0d", i, player, exp_n3[i]);
            end
        end
    endtask

    task automatic test_win();
        int a0;
        N = 2'd3;
        do_reset();
        press_start();
        mismatch_turn();
        press_flip();
        go = 1'b1; tick();
        tick(); go = 1'b0;
        W = 1'b1; tick();
        tick(); W = 1'b0;
        checks++; if (game_over !== 1'b1) begin errors++; $display("FAIL win_game_over: got %0b expected 1", game_over); end
        checks++; if (winner !== 2'd1) begin errors++; $display("FAIL win_winner: got %0d expected 1", winner); end
        a0 = a_cnt;
        press_flip(); tick(); tick();
        checks++; if (a_cnt !== a0) begin errors++; $display("FAIL win_flip_ignored: A pulses got %0d expected 0", a_cnt - a0); end
        checks++; if (game_over !== 1'b1 || winner !== 2'd1) begin errors++; $display("FAIL win_hold: game_over=%0b winner=%0d expected 1 1", game_over, winner); end
        press_start();
        checks++; if (game_over !== 1'b0) begin errors++; $display("FAIL win_exit: game_over got %0b expected 0", game_over); end
        a0 = a_cnt;
        press_flip(); tick();
        checks++; if (a_cnt !== a0) begin errors++; $display("FAIL idle_flip_ignored: A pulses got %0d expected 0", a_cnt - a0); end
    endtask

    task automatic test_held_flip();
        int a0;
        int n0;
        N = 2'd2;
        do_reset();
        press_start();
        a0 = a_cnt; n0 = nt_cnt;
        go = 1'b0;
        flip = 1'b1;
        repeat (10) tick();
        flip = 1'b0;
        repeat (12) tick();
        checks++; if (a_cnt - a0 !== 1) begin errors++; $display("FAIL held_flip_A: pulses got %0d expected 1", a_cnt - a0); end
        checks++; if (nt_cnt - n0 !== 1) begin errors++; $display("FAIL held_flip_next_turn: pulses got %0d expected 1", nt_cnt - n0); end
    endtask

    task automatic test_back_to_back();
        int a0;
        N = 2'd2;
        do_reset();
        a0 = a_cnt;
        start = 1'b1; flip = 1'b1;
        tick(); tick();
        start = 1'b0; flip = 1'b0;
        tick();
        checks++; if (a_cnt !== a0) begin errors++; $display("FAIL priority_flip_ignored: A pulses got %0d expected 0", a_cnt - a0); end
        press_flip();
        checks++; if (A !== 1'b1) begin errors++; $display("FAIL priority_start_taken: A got %0b expected 1", A); end
    endtask

    task automatic test_reset_midturn();
        int n0;
        N = 2'd2;
        do_reset();
        press_start();
        mismatch_turn();
        press_flip();
        go = 1'b0; tick();
`ifdef REVEAL_TIMER_EN
        tick(); tick();
`endif
        n0 = nt_cnt;
        rst = 1'b1; tick();
        checks++; if ({A, B, nt, game_over} !== 4'b0000) begin errors++; $display("FAIL midreset_strobes: A=%0b B=%0b nt=%0b go=%0b expected all 0", A, B, nt, game_over); end
        checks++; if (player !== 2'd0 || winner !== 2'd0) begin errors++; $display("FAIL midreset_regs: player=%0d winner=%0d expected 0 0", player, winner); end
        rst = 1'b0;
        repeat (10) tick();
        checks++; if (nt_cnt !== n0) begin errors++; $display("FAIL midreset_no_next_turn: pulses got %0d expected 0", nt_cnt - n0); end
        n0 = a_cnt;
        press_flip(); tick();
        checks++; if (a_cnt !== n0) begin errors++; $display("FAIL midreset_idle: A pulses got %0d expected 0", a_cnt - n0); end
    endtask

    initial begin
        checks = 0; errors = 0; a_cnt = 0; nt_cnt = 0;
        rst = 1'b1; start = 1'b0; flip = 1'b0; go = 1'b0; W = 1'b0; N = 2'd0;
        test_reset();
        test_match_no_win();
        test_mismatch_reveal();
        test_player_counts();
        test_win();
        test_held_flip();
        test_back_to_back();
        test_reset_midturn();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
